// File: rtl/bcd_disp_pkg.sv
// Shared constants for the BCD scan display: 7-segment patterns ({g,f,e,d,c,b,a},
// active-high) and a width helper for the scan counters.
package bcd_disp_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Counter width able to hold 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bcd_seg_decode.sv
// Combinational BCD nibble to 7-segment decoder; codes 10..15 show 'E'.
module bcd_seg_decode
  import bcd_disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Table lookup of the segment pattern for one nibble.
  always_comb begin
    seg = SEG_E;
    case (nibble)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_E;
    endcase
  end

endmodule

// File: rtl/bcd_scan_display.sv
// Captures a packed set of BCD digits on a load strobe and time-multiplexes them
// onto one 7-segment bus with one-hot digit enables, leading-zero blanking and a
// sticky flag for non-BCD input.
module bcd_scan_display
  import bcd_disp_pkg::*;
#(
  parameter int NDIG     = 4,
  parameter int SCAN_DIV = 4,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic              stepclk,
  input  logic              reset,
  input  logic              load,
  input  logic [4*NDIG-1:0] digits,
  input  logic [NDIG-1:0]   dp_in,
  input  logic              err_clr,
  output logic [6:0]        seg_out,
  output logic              dp_out,
  output logic [NDIG-1:0]   an_out,
  output logic              err_out
);

  localparam int IDX_W = cnt_w(NDIG);
  localparam int PRE_W = cnt_w(SCAN_DIV);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIG - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);

  logic [3:0]       cap_nib_p0 [NDIG];
  logic [NDIG-1:0]  cap_dp_p0;
  logic [PRE_W-1:0] presc;
  logic [IDX_W-1:0] idx;
  logic             err_q;

  logic [6:0]       seg_p1;
  logic             dp_p1;
  logic [NDIG-1:0]  an_p1;

  logic             bad_in;
  logic [NDIG-1:0]  show_mask;
  logic [3:0]       sel_nib;
  logic [6:0]       sel_seg;

  // Flag any incoming nibble outside 0..9.
  always_comb begin
    bad_in = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (digits[4*i +: 4] > 4'd9) bad_in = 1'b1;
    end
  end

  // A digit is shown if it or any higher digit is nonzero; digit 0 always shows.
  always_comb begin : mask_calc
    logic nz;
    nz        = 1'b0;
    show_mask = '0;
    for (int i = NDIG - 1; i >= 0; i--) begin
      nz           = nz | (cap_nib_p0[i] != 4'd0);
      show_mask[i] = nz | (i == 0) | !BLANK_LZ;
    end
  end

  assign sel_nib = cap_nib_p0[idx];

  bcd_seg_decode u_dec (
    .nibble (sel_nib),
    .seg    (sel_seg)
  );

  // ---- stage p0: capture register ----
  // Digits and decimal points are held until the next load strobe.
  always_ff @(posedge stepclk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NDIG; i++) cap_nib_p0[i] <= 4'd0;
      cap_dp_p0 <= '0;
    end else if (load) begin
      for (int i = 0; i < NDIG; i++) cap_nib_p0[i] <= digits[4*i +: 4];
      cap_dp_p0 <= dp_in;
    end
  end

  // Prescaler paces the scan; the digit index steps when it wraps.
  always_ff @(posedge stepclk or posedge reset) begin
    if (reset) begin
      presc <= '0;
      idx   <= '0;
    end else if (presc == PRE_LAST) begin
      presc <= '0;
      idx   <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
    end else begin
      presc <= presc + PRE_W'(1);
    end
  end

  // Sticky error: a bad load sets it and takes priority over a clear.
  always_ff @(posedge stepclk or posedge reset) begin
    if (reset)                err_q <= 1'b0;
    else if (load && bad_in)  err_q <= 1'b1;
    else if (err_clr)         err_q <= 1'b0;
  end

  // ---- stage p1: registered display outputs ----
  // Drive the currently indexed digit, blanking leading zeros on segments only.
  always_ff @(posedge stepclk or posedge reset) begin
    if (reset) begin
      seg_p1 <= SEG_BLANK;
      dp_p1  <= 1'b0;
      an_p1  <= '0;
    end else begin
      seg_p1 <= show_mask[idx] ? sel_seg : SEG_BLANK;
      dp_p1  <= cap_dp_p0[idx];
      an_p1  <= NDIG'(1) << idx;
    end
  end

  assign seg_out = seg_p1;
  assign dp_out  = dp_p1;
  assign an_out  = an_p1;
  assign err_out = err_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Bench for bcd_scan_display: three instances (default, no blanking, SCAN_DIV=1)
// driven by common stimulus and compared against a time-based reference model.
module tb_bcd_scan_display;

  logic        stepclk = 1'b0;
  logic        reset, load, err_clr;
  logic [15:0] digits;
  logic [3:0]  dp_in;

  logic [6:0] seg_a, seg_b, seg_c;
  logic       dp_a, dp_b, dp_c;
  logic [3:0] an_a, an_b, an_c;
  logic       err_a, err_b, err_c;

  bcd_scan_display #(.NDIG(4), .SCAN_DIV(4), .BLANK_LZ(1'b1)) dut_a (
    .stepclk(stepclk), .reset(reset), .load(load), .digits(digits), .dp_in(dp_in),
    .err_clr(err_clr), .seg_out(seg_a), .dp_out(dp_a), .an_out(an_a), .err_out(err_a));

  bcd_scan_display #(.NDIG(4), .SCAN_DIV(4), .BLANK_LZ(1'b0)) dut_b (
    .stepclk(stepclk), .reset(reset), .load(load), .digits(digits), .dp_in(dp_in),
    .err_clr(err_clr), .seg_out(seg_b), .dp_out(dp_b), .an_out(an_b), .err_out(err_b));

  bcd_scan_display #(.NDIG(4), .SCAN_DIV(1), .BLANK_LZ(1'b1)) dut_c (
    .stepclk(stepclk), .reset(reset), .load(load), .digits(digits), .dp_in(dp_in),
    .err_clr(err_clr), .seg_out(seg_c), .dp_out(dp_c), .an_out(an_c), .err_out(err_c));

  always #5 stepclk = ~stepclk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: captured values plus the number of edges since reset.
  int m_cap [4];
  int m_dp  [4];
  int m_err;
  int m_t;
  int seg_tbl [16] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07,
                       'h7F, 'h6F, 'h79, 'h79, 'h79, 'h79, 'h79, 'h79};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int m_idx(input int sd);
    return (m_t / sd) % 4;
  endfunction

  function automatic int m_seg(input int sd, input bit blz);
    int  i;
    bit  allz;
    i = m_idx(sd);
    if (blz && i > 0) begin
      allz = 1'b1;
      for (int j = i; j < 4; j++) if (m_cap[j] != 0) allz = 1'b0;
      if (allz) return 0;
    end
    return seg_tbl[m_cap[i]];
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 4; k++) begin
      m_cap[k] = 0;
      m_dp[k]  = 0;
    end
    m_err = 0;
    m_t   = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_segA"}, seg_a, 0); chk({tag, "_anA"}, an_a, 0);
    chk({tag, "_dpA"},  dp_a,  0); chk({tag, "_errA"}, err_a, 0);
    chk({tag, "_segB"}, seg_b, 0); chk({tag, "_anB"}, an_b, 0);
    chk({tag, "_segC"}, seg_c, 0); chk({tag, "_anC"}, an_c, 0);
  endtask

  // One clock edge: predict outputs from pre-edge model state, update the model
  // with the inputs present at the edge, then compare just after the edge.
  task automatic step();
    int ea_seg, ea_an, ea_dp, eb_seg, eb_dp, ec_seg, ec_an, ec_dp;
    @(posedge stepclk);
    ea_seg = m_seg(4, 1'b1); ea_an = 1 << m_idx(4); ea_dp = m_dp[m_idx(4)];
    eb_seg = m_seg(4, 1'b0);                        eb_dp = m_dp[m_idx(4)];
    ec_seg = m_seg(1, 1'b1); ec_an = 1 << m_idx(1); ec_dp = m_dp[m_idx(1)];
    if (err_clr) m_err = 0;
    if (load) begin
      for (int k = 0; k < 4; k++) begin
        if (digits[4*k +: 4] > 4'd9) m_err = 1;
        m_cap[k] = int'(digits[4*k +: 4]);
        m_dp[k]  = int'(dp_in[k]);
      end
    end
    m_t++;
    #1;
    chk("segA", seg_a, ea_seg); chk("anA", an_a, ea_an); chk("dpA", dp_a, ea_dp);
    chk("segB", seg_b, eb_seg); chk("anB", an_b, ea_an); chk("dpB", dp_b, eb_dp);
    chk("segC", seg_c, ec_seg); chk("anC", an_c, ec_an); chk("dpC", dp_c, ec_dp);
    chk("errA", err_a, m_err);  chk("errB", err_b, m_err); chk("errC", err_c, m_err);
  endtask

  // Asynchronous reset pulse placed between edges.
  task automatic do_reset(input string tag);
    #2 reset = 1'b1;
    #1 chk_zero(tag);
    model_clear();
    #2 reset = 1'b0;
    #1 chk_zero({tag, "_rel"});
  endtask

  task automatic load_word(input logic [15:0] v, input int hold);
    digits = v;
    dp_in  = 4'($urandom);
    load   = 1'b1;
    step();
    load   = 1'b0;
    repeat (hold) step();
  endtask

  initial begin
    int cnt;
    reset = 1'b1; load = 1'b0; err_clr = 1'b0; digits = '0; dp_in = '0;
    model_clear();
    #1 chk_zero("rst0");
    #1 reset = 1'b0;

    // First edge after release shows digit 0 as '0'.
    step();
    chk("first_an", an_a, 4'b0001);
    chk("first_seg", seg_a, 7'h3F);
    repeat (6) step();

    // Normal scan of 1234.
    load_word(16'h1234, 20);

    // Reset in the middle of digit 2, then the scan restarts at digit 0.
    while (m_t % 16 != 10) step();
    chk("mid_an", an_a, 4'b0100);
    do_reset("midrst");
    step();
    chk("post_an", an_a, 4'b0001);
    chk("post_seg", seg_a, 7'h3F);

    // Leading-zero blanking (instance B shows all digits).
    load_word(16'h0070, 16);
    load_word(16'h0000, 16);

    // Invalid codes and the sticky error flag.
    load_word(16'h00A5, 0);
    chk("err_set", err_a, 1'b1);
    repeat (16) step();
    load_word(16'h0005, 4);
    chk("err_sticky", err_a, 1'b1);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    chk("err_clr", err_a, 1'b0);
    err_clr = 1'b1;
    load_word(16'h000B, 0);
    err_clr = 1'b0;
    chk("err_setwins", err_a, 1'b1);
    repeat (8) step();

    // Capture isolation: digits churn while load is low.
    load_word(16'h4321, 2);
    repeat (16) begin
      digits = 16'($urandom);
      step();
    end

    // Digit 0 driven from a mod-10 counter, one load per count.
    err_clr = 1'b1; step(); err_clr = 1'b0;
    cnt = 0;
    repeat (10) begin
      load_word({12'h000, 4'(cnt)}, 4);
      cnt = (cnt + 1) % 10;
    end
    load_word(16'h000F, 8);
    chk("cnt_err", err_a, 1'b1);

    // Randomized traffic, mostly BCD with occasional invalid codes and resets.
    repeat (400) begin
      for (int k = 0; k < 4; k++) begin
        case ($urandom % 8)
          0, 1, 2: digits[4*k +: 4] = 4'd0;
          7:       digits[4*k +: 4] = 4'(10 + $urandom % 6);
          default: digits[4*k +: 4] = 4'($urandom % 10);
        endcase
      end
      dp_in   = 4'($urandom);
      load    = ($urandom % 4 == 0);
      err_clr = ($urandom % 8 == 0);
      if ($urandom % 60 == 0) do_reset("rndrst");
      step();
    end
    load = 1'b0; err_clr = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/bcd_scan_display.md
# bcd_scan_display

Downstream consumer of the BCD counter stage. Captures a packed set of BCD digits (digit 0 typically driven by the counter's 4-bit count output) on a load strobe, then time-multiplexes them onto a single 7-segment bus with one-hot digit enables. Also provides leading-zero blanking and invalid-code display, and raises a sticky error flag for non-BCD input. Sits between the counter stage and the board display pins.

## Interface
- NDIG, 4: number of digits scanned (1..8)
- SCAN_DIV, 4: stepclk cycles each digit stays enabled (1..256)
- BLANK_LZ, 1: 1 = blank leading zeros, 0 = show all digits
- stepclk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- load  in  1  capture strobe; digits/dp_in sampled on the rising edge where load=1
- digits  in  4*NDIG  packed BCD; digit i = digits[4i+3:4i], digit 0 least significant
- dp_in  in  NDIG  decimal point per digit
- err_clr  in  1  clears err_out
- seg_out  out  7  segments {g,f,e,d,c,b,a}, active-high
- dp_out  out  1  decimal point of the enabled digit, active-high
- an_out  out  NDIG  one-hot digit enable, active-high
- err_out  out  1  sticky: a loaded digit was > 9

## Operation
- Capture register: holds NDIG nibbles plus NDIG dp bits. Loads when load=1, otherwise holds. Changes on `digits` while load=0 are ignored.
- Prescaler: counts 0..SCAN_DIV-1 and wraps.
- Digit index: 0..NDIG-1. Advances by one when the prescaler wraps. Wraps from NDIG-1 to 0.
- Decode of the captured nibble at the current index:
  - 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07, 8:7F, 9:6F.
  - 10..15 give 79 ('E').
- Blanking (BLANK_LZ=1):
  - Digit i>0 is blanked when its nibble and all higher nibbles equal 0. A blanked digit shows seg_out=00.
  - A nibble >9 counts as nonzero.
  - Digit 0 is never blanked.
  - dp_out is still driven from dp_in on blanked digits.
- Error flag:
  - Set on any edge where load=1 and any incoming nibble >9.
  - Cleared on an edge where err_clr=1.
  - If set and clear occur on the same edge, set wins.

## Timing
- Reset values (asynchronous, held while reset=1): seg_out=00, dp_out=0, an_out=0 (all digits off), err_out=0, prescaler=0, index=0, capture register all zero.
- Outputs are registered, so there is no combinational path from inputs to outputs.
- First rising edge after reset release: an_out=one-hot bit 0, seg_out shows digit 0 (3F). The index stays at 0 for SCAN_DIV edges total, then goes to 1.
- Load latency: a load on edge k is visible on seg_out/dp_out at edge k+1, if that digit is enabled at k+1.
- With SCAN_DIV=1 the index advances every edge.
- A full scan period is NDIG*SCAN_DIV cycles.
- Reset asserted mid-scan: outputs drop to reset values without waiting for a clock edge. The scan restarts from digit 0.
- load=1 for consecutive edges: each edge recaptures; the last capture wins.

## Structure
- Package bcd_disp_pkg holds:
  - segment constants SEG_0..SEG_9, SEG_E=7'h79, SEG_BLANK=7'h00
  - localparam width helpers for the index/prescaler (clog2 of NDIG and SCAN_DIV).
- Sub-module bcd_seg_decode: combinational 4-bit to 7-segment decoder including the 'E' mapping. The top module instantiates it once on the selected nibble.
- The top module contains the capture register, prescaler, index, blanking mask and error flag.

## Test plan
All scenarios use NDIG=4, SCAN_DIV=4, BLANK_LZ=1 unless noted.
- Reset mid-scan: assert reset between edges during digit 2 → all outputs 0 within the same timestep. Release reset → first edge gives an_out=0001, seg_out=3F.
- Load 16'h1234 → over the next 16 edges an_out steps 0001/0010/0100/1000 with seg_out 66/4F/5B/06, four edges each, then wraps to 0001.
- Leading-zero blanking:
  - Load 16'h0070 → seg_out 3F, 07, 00, 00 for digits 0..3.
  - Load 16'h0000 → only digit 0 shows 3F.
  - Same loads with BLANK_LZ=0 → all digits shown, non-zero digits as decoded and zeros as 3F.
- Invalid code handling:
  - Load 16'h00A5 → digit 1 shows 79; err_out=1 from the next edge.
  - Load 16'h0005 → err_out stays 1 (sticky).
  - err_clr=1 → err_out=0.
  - err_clr=1 and load 16'h000B on the same edge → err_out=1.
- Capture isolation: hold load=0 while `digits` changes every cycle → seg_out is unchanged.
- Counter source: drive digit 0 from the BCD counter and pulse load once per counter step → digit 0 follows 0..9. Then load 16'h000F → digit 0 shows 79 and err_out=1.
- Scan wrap with SCAN_DIV=1: an_out rotates 0001→0010→0100→1000→0001 on consecutive edges.
